// File: rtl/wb_cmd_master.sv
// Wishbone pipelined-mode initiator: one valid/ready command becomes one bus transaction, answered on a valid/ready response port.
// Optional abort-on-timeout is enabled by defining WBM_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        done_s;
  logic        tmo_s;
  logic        tmo_hit_s;

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;

  assign tmo_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = rsp_err_q;

  // Counter runs only while a bus cycle is open; it restarts from zero for every command.
  always_comb begin
    cnt_d     = '0;
    rsp_err_d = rsp_err_q;
    if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
    if (tmo_s) begin
      rsp_err_d = 1'b1;
    end else if (done_s) begin
      rsp_err_d = 1'b0;
    end else begin
      rsp_err_d = rsp_err_q;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Next-state and output logic; acks outside REQ/WAIT fall through untouched.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    done_s      = 1'b0;
    tmo_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_data;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (!i_wb_stall && i_wb_ack) begin
          done_s = 1'b1;
        end else if (tmo_hit_s) begin
          tmo_s = 1'b1;
        end else if (!i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (i_wb_ack) begin
          done_s = 1'b1;
        end else if (tmo_hit_s) begin
          tmo_s = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // Both exits close the bus cycle and present a response; an ack beats expiry above.
    if (done_s) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_data_d  = we_q ? 32'h0000_0000 : i_wb_data;
      rsp_valid_d = 1'b1;
      state_d     = S_RESP;
    end else if (tmo_s) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_data_d  = 32'h0000_0000;
      rsp_valid_d = 1'b1;
      state_d     = S_RESP;
    end else begin
      rsp_data_d  = rsp_data_d;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: table of directed transactions against a small LED/button responder, plus hand-written corner sequences.
module tb_wb_cmd_master;

  localparam logic [31:0] LED_ADDR = 32'h3000_0000;
  localparam logic [31:0] BTN_ADDR = 32'h3000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        i_wb_ack, i_wb_stall;
  logic [31:0] i_wb_data;

  // Responder model controls
  logic [31:0] led_q;
  logic [2:0]  buttons = 3'b101;
  logic [3:0]  stb_age_q;
  logic [3:0]  stall_cfg = 4'd0;
  logic        ack_en = 1'b1;
  logic        comb_ack = 1'b0;
  logic        spur_ack = 1'b0;
  logic        ack_q;
  logic [31:0] rd_val;

  int checks = 0;
  int failures = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
  );

  always #5 clk = ~clk;

  // Responder: stalls the first stall_cfg strobe cycles, then acks next cycle (or same cycle in comb mode).
  assign i_wb_stall = o_wb_stb && (stb_age_q < stall_cfg);
  assign i_wb_ack   = ack_q || spur_ack ||
                      (comb_ack && ack_en && o_wb_cyc && o_wb_stb && !i_wb_stall);
  assign i_wb_data  = rd_val;

  always_comb begin
    if (o_wb_addr == LED_ADDR)      rd_val = led_q;
    else if (o_wb_addr == BTN_ADDR) rd_val = {29'h0, buttons};
    else                            rd_val = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    stb_age_q <= !o_wb_stb ? 4'd0 : ((stb_age_q == 4'd15) ? 4'd15 : stb_age_q + 4'd1);
    ack_q     <= !comb_ack && ack_en && o_wb_cyc && o_wb_stb && !i_wb_stall;
    if (reset) led_q <= 32'h0;
    else if (o_wb_cyc && o_wb_stb && !i_wb_stall && o_wb_we && o_wb_addr == LED_ADDR)
      led_q <= o_wb_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  stall;
    logic        comb;
    int          rdy_delay;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  // Drives one command from a negedge, follows it to the response and consumes it.
  task automatic run_vec(input vec_t v, input int idx);
    int lat, stbc, bad;
    logic [31:0] snap;
    string tag;
    tag = $sformatf("v%0d", idx);
    stall_cfg = v.stall; comb_ack = v.comb; ack_en = 1'b1;
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_data = v.data;
    chk({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_data = 32'h0;
    lat = 1; stbc = 0; bad = 0;
    while (!rsp_valid && lat < 40) begin
      if (o_wb_stb) begin
        stbc++;
        if (o_wb_addr !== v.addr || o_wb_we !== v.we || !o_wb_cyc ||
            (v.we && o_wb_data !== v.data)) bad++;
      end
      if (cmd_ready || !busy) bad++;
      @(negedge clk); lat++;
    end
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_stb_cycles"}, stbc, v.stall + 1);
    chk({tag, "_bus_stable"}, bad, 0);
    chk({tag, "_rsp_data"}, rsp_data, v.exp_data);
    chk({tag, "_rsp_err_cyc"}, {30'h0, rsp_err, o_wb_cyc}, 32'd0);
    snap = rsp_data; bad = 0;
    // Hold the response with a competing command and a spurious ack present.
    for (int i = 0; i < v.rdy_delay; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = LED_ADDR; cmd_data = 32'h0000_00FF;
      spur_ack = (i == 0);
      @(negedge clk);
      if (!rsp_valid || rsp_data !== snap || cmd_ready || o_wb_cyc || o_wb_stb) bad++;
    end
    spur_ack = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_data = 32'h0;
    if (v.rdy_delay > 0) chk({tag, "_rsp_hold"}, bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_after_consume"}, {30'h0, rsp_valid, cmd_ready}, 32'd1);
    if (v.we && v.addr == LED_ADDR) chk({tag, "_led"}, led_q, v.data);
  endtask

  initial begin
    int cycc;
    //        we    addr      data          stall comb rdy exp_data       lat
    vecs[0] = '{1'b1, LED_ADDR, 32'h0000_00A5, 4'd0, 1'b0, 0, 32'h0000_0000, 3};
    vecs[1] = '{1'b0, BTN_ADDR, 32'h1234_5678, 4'd0, 1'b0, 0, 32'h0000_0005, 3};
    vecs[2] = '{1'b0, BTN_ADDR, 32'h0000_0000, 4'd3, 1'b0, 5, 32'h0000_0005, 6};
    vecs[3] = '{1'b1, LED_ADDR, 32'h0000_003C, 4'd2, 1'b0, 0, 32'h0000_0000, 5};
    vecs[4] = '{1'b0, LED_ADDR, 32'h0000_0000, 4'd1, 1'b0, 2, 32'h0000_003C, 4};
    vecs[5] = '{1'b0, 32'h3000_0008, 32'h0, 4'd0, 1'b1, 0, 32'hDEAD_BEEF, 2};
    vecs[6] = '{1'b0, LED_ADDR, 32'h0000_0000, 4'd7, 1'b1, 0, 32'h0000_003C, 9};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_outputs", {26'h0, rsp_valid, rsp_err, busy, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
    chk("reset_data", rsp_data | o_wb_addr | o_wb_data, 32'd0);
    chk("reset_cmd_ready", {31'h0, cmd_ready}, 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Spurious ack while idle must change nothing.
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    chk("idle_spur_ack", {29'h0, busy, rsp_valid, o_wb_cyc}, 32'd0);

    // Unanswered read: aborts after 8 cycles with the timeout build, hangs otherwise.
    ack_en = 1'b0; stall_cfg = 4'd0; comb_ack = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0100;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 32'h0;
    cycc = 0;
    for (int n = 0; n < 30; n++) begin
      if (o_wb_cyc) cycc++;
      @(negedge clk);
    end
`ifdef WBM_TIMEOUT_EN
    chk("tmo_cyc_cycles", cycc, 8);
    chk("tmo_rsp", {30'h0, rsp_valid, rsp_err}, 32'd3);
    chk("tmo_rsp_data", rsp_data, 32'h0);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    chk("tmo_late_ack", {29'h0, rsp_valid, rsp_err, busy}, 32'd7);
`else
    chk("hang_cyc_cycles", cycc, 30);
    chk("hang_state", {30'h0, busy, rsp_valid}, 32'd2);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    chk("hang_release", {30'h0, rsp_valid, rsp_err}, 32'd2);
    chk("hang_rsp_data", rsp_data, 32'hDEAD_BEEF);
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("tmo_consumed", {30'h0, rsp_valid, cmd_ready}, 32'd1);

    // Reset while waiting for an ack, then a normal write.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = LED_ADDR;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 32'h0;
    @(negedge clk);
    chk("rst_in_wait", {30'h0, o_wb_cyc, o_wb_stb}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_drop", {27'h0, o_wb_cyc, o_wb_stb, rsp_valid, busy, cmd_ready}, 32'd1);
    reset = 1'b0;
    run_vec('{1'b1, LED_ADDR, 32'h0000_005A, 4'd0, 1'b0, 0, 32'h0, 3}, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
